// File: rtl/instr_io_loader_if.sv
// Host-side bus of the instruction streamer: preload port, run control and pad drive.
// No latency of its own; pure signal bundle.
// No backpressure: the streamer paces itself off instFlag, the host only issues strobes.
interface instr_io_loader_if #(
  parameter int AW = 4
);
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [AW:0]   count;
  logic          start;
  logic          instFlag;
  logic [15:0]   io_out;
  logic          io_en;
  logic [AW:0]   word_idx;
  logic          busy;
  logic          done;
  logic          overrun;

  // Host / testbench side
  modport master (
    output load_we, load_addr, load_data, count, start, instFlag,
    input  io_out, io_en, word_idx, busy, done, overrun
  );

  // Streamer side
  modport slave (
    input  load_we, load_addr, load_data, count, start, instFlag,
    output io_out, io_en, word_idx, busy, done, overrun
  );
endinterface

// File: rtl/instr_io_loader.sv
// Streams preloaded 16-bit words onto the io pad bus, one per instFlag rise (optional IO_LOADER_LOOP_EN: wrap forever).
// Latency: word and io_en registered on the edge that samples the rise, held HOLD cycles.
// No backpressure: a rise during a drive window only sets the sticky overrun flag and is dropped.
module instr_io_loader #(
  parameter  int DEPTH = 16,
  parameter  int HOLD  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              reset,
  instr_io_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_DRIVE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD - 1);

  state_t        state_q, state_d;
  logic          flag_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic [15:0]   io_out_q, io_out_d;
  logic          io_en_q, io_en_d;
  logic [7:0]    hold_q, hold_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic [15:0]   mem [DEPTH];

  logic          rise;
  logic          busy;
  logic [AW:0]   eff_cnt;
  logic [AW:0]   idx_inc;
  logic          last_word;

  assign rise      = bus.instFlag & ~flag_q;
  assign busy      = (state_q == S_ARM) || (state_q == S_DRIVE);
  assign eff_cnt   = (bus.count > DEPTH_W) ? DEPTH_W : bus.count;
  assign idx_inc   = idx_q + 1'b1;
  assign last_word = (idx_inc == cnt_q);

  // Word buffer: host writes only while not streaming; deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.load_we && !busy) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      io_out_q <= '0;
      io_en_q  <= 1'b0;
      hold_q   <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_q   <= bus.instFlag;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      io_out_q <= io_out_d;
      io_en_q  <= io_en_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = (eff_cnt != '0) ? S_ARM : S_DONE;
        end
      end
      S_ARM: begin
        if (rise) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (hold_q == '0) begin
`ifdef IO_LOADER_LOOP_EN
          state_d = S_ARM;
`else
          state_d = last_word ? S_DONE : S_ARM;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates per state: run setup, word launch, hold countdown, flags
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    io_out_d = io_out_q;
    io_en_d  = io_en_q;
    hold_d   = hold_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        io_en_d = 1'b0;
        if (bus.start && (eff_cnt != '0)) begin
          cnt_d  = eff_cnt;
          idx_d  = '0;
          done_d = 1'b0;
          ovr_d  = 1'b0;
        end else if (bus.start) begin
`ifndef IO_LOADER_LOOP_EN
          done_d = 1'b1;
`endif
        end
      end
      S_ARM: begin
        if (rise) begin
          io_out_d = mem[idx_q[AW-1:0]];
          io_en_d  = 1'b1;
          hold_d   = HOLD_INIT;
        end
      end
      S_DRIVE: begin
        // A rise here is too early for the next word; flag it and drop it
        if (rise) begin
          ovr_d = 1'b1;
        end
        if (hold_q != '0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          io_en_d = 1'b0;
          if (last_word) begin
`ifdef IO_LOADER_LOOP_EN
            idx_d  = '0;
`else
            idx_d  = idx_inc;
            done_d = 1'b1;
`endif
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.io_out   = io_out_q;
  assign bus.io_en    = io_en_q;
  assign bus.word_idx = idx_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_instr_io_loader.sv
// Bench for instr_io_loader: random instFlag spacing and buffer contents, scoreboarded drive windows.
// Expected words queued at start; monitor pops on each io_en window.
// Flag pacing comes from the bench; the DUT has no stall input.
module tb_instr_io_loader;
  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_io_loader_if #(.AW(AW)) bus_if();

  instr_io_loader #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          win_cnt = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each io_en window must carry the next queued word for exactly HOLD cycles
  logic        prev_en = 1'b0;
  logic [15:0] cur_w = '0;
  int          win_len = 0;
  always @(posedge clk) begin
    #1;
    if (bus_if.io_en === 1'b1 && !prev_en) begin
      win_cnt++;
      win_len = 1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_window: got io_out 0x%0h, expected no drive", bus_if.io_out);
        cur_w = bus_if.io_out;
      end else begin
        cur_w = exp_q.pop_front();
        check("window_word", bus_if.io_out, cur_w);
      end
    end else if (bus_if.io_en === 1'b1 && prev_en) begin
      win_len++;
      check("held_word", bus_if.io_out, cur_w);
    end else if (bus_if.io_en !== 1'b1 && prev_en) begin
      if (!reset) check("window_len", win_len, HOLD);
    end
    prev_en = (bus_if.io_en === 1'b1);
  end

  task automatic write_word(input int a, input logic [15:0] d, input bit accepted);
    @(negedge clk);
    bus_if.load_we   = 1'b1;
    bus_if.load_addr = a[AW-1:0];
    bus_if.load_data = d;
    @(negedge clk);
    bus_if.load_we   = 1'b0;
    if (accepted) model_mem[a] = d;
  endtask

  task automatic start_run(input int cnt, input bit wr, input int wa, input logic [15:0] wd,
                           output int eff, output int w0);
    @(negedge clk);
    bus_if.count = cnt[AW:0];
    bus_if.start = 1'b1;
    if (wr) begin
      bus_if.load_we   = 1'b1;
      bus_if.load_addr = wa[AW-1:0];
      bus_if.load_data = wd;
      model_mem[wa]    = wd;
    end
    eff = (cnt > DEPTH) ? DEPTH : cnt;
    w0  = win_cnt;
    for (int i = 0; i < eff; i++) exp_q.push_back(model_mem[i]);
    @(negedge clk);
    bus_if.start   = 1'b0;
    bus_if.load_we = 1'b0;
  endtask

  // Pulse instFlag with rise-to-rise spacing in [pmin,pmax] until the run ends
  task automatic stream(input int pmin, input int pmax, input bit ovr, input int win_target);
    int ctr = 0;
    int cyc = 0;
    int per;
    int w;
    bit first = 1'b1;
    bit fin = 1'b0;
    per = $urandom_range(pmax, pmin);
    w   = ovr ? 1 : $urandom_range(2, 1);
    while (!fin && cyc < 2000) begin
      bus_if.instFlag = (ctr < w) || (ovr && first && ctr == 2);
      @(negedge clk);
      cyc++;
      ctr++;
      if (ctr >= per) begin
        ctr   = 0;
        first = 1'b0;
        per   = $urandom_range(pmax, pmin);
        w     = $urandom_range(2, 1);
      end
      if (!bus_if.busy) fin = 1'b1;
      if (win_target > 0 && win_cnt >= win_target && !bus_if.io_en) fin = 1'b1;
    end
    bus_if.instFlag = 1'b0;
    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL stream_timeout: got %0d cycles without finishing, expected end of run", cyc);
    end
  endtask

  task automatic finish_check(input int eff, input bit exp_ovr, input int w0);
    check("done", bus_if.done, 1);
    check("busy_end", bus_if.busy, 0);
    check("word_idx_end", bus_if.word_idx, eff);
    check("overrun_end", bus_if.overrun, exp_ovr);
    check("window_count", win_cnt - w0, eff);
    check("queue_left", exp_q.size(), 0);
    if (eff > 0) check("io_out_held", bus_if.io_out, model_mem[eff-1]);
  endtask

  task automatic check_reset_state();
    check("rst_io_en", bus_if.io_en, 0);
    check("rst_io_out", bus_if.io_out, 0);
    check("rst_word_idx", bus_if.word_idx, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_overrun", bus_if.overrun, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int eff, w0, cyc, cnt;
    logic [15:0] plan [6];
    plan[0] = 16'h1005; plan[1] = 16'h2003; plan[2] = 16'h300A;
    plan[3] = 16'h400F; plan[4] = 16'h5007; plan[5] = 16'h6001;

    reset = 1'b1;
    bus_if.load_we = 1'b0; bus_if.load_addr = '0; bus_if.load_data = '0;
    bus_if.count = '0; bus_if.start = 1'b0; bus_if.instFlag = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) write_word(i, plan[i], 1'b1);
    for (int i = 6; i < DEPTH; i++) write_word(i, 16'($urandom), 1'b1);

`ifdef IO_LOADER_LOOP_EN
    start_run(2, 1'b0, 0, 16'h0, eff, w0);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(model_mem[0]);
      exp_q.push_back(model_mem[1]);
    end
    stream(22, 22, 1'b0, w0 + 6);
    check("loop_window_count", win_cnt - w0, 6);
    check("loop_done", bus_if.done, 0);
    check("loop_busy", bus_if.busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    check_reset_state();
`else
    // count 0: straight to done, no drive even with flag activity
    start_run(0, 1'b0, 0, 16'h0, eff, w0);
    check("cnt0_done", bus_if.done, 1);
    check("cnt0_busy", bus_if.busy, 0);
    for (int i = 0; i < 6; i++) begin
      bus_if.instFlag = i[0];
      @(negedge clk);
    end
    bus_if.instFlag = 1'b0;
    check("cnt0_windows", win_cnt - w0, 0);

    // Plan sequence; a write issued while busy must not land
    start_run(6, 1'b0, 0, 16'h0, eff, w0);
    check("start_clears_done", bus_if.done, 0);
    write_word(2, 16'hBEEF, 1'b0);
    stream(22, 22, 1'b0, 0);
    finish_check(eff, 1'b0, w0);

    // The same write while not busy is accepted
    write_word(2, 16'hBEEF, 1'b1);
    start_run(3, 1'b0, 0, 16'h0, eff, w0);
    stream(HOLD + 1, 12, 1'b0, 0);
    finish_check(eff, 1'b0, w0);

    // Early second rise: overrun, full-length windows regardless
    start_run(2, 1'b0, 0, 16'h0, eff, w0);
    stream(22, 22, 1'b1, 0);
    finish_check(eff, 1'b1, w0);

    // Write coincident with start lands first; start clears overrun
    start_run(4, 1'b1, 0, 16'($urandom), eff, w0);
    check("start_clears_ovr", bus_if.overrun, 0);
    stream(HOLD + 1, 25, 1'b0, 0);
    finish_check(eff, 1'b0, w0);

    // Random counts (including saturating ones) and random contents
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) write_word($urandom_range(DEPTH - 1, 0), 16'($urandom), 1'b1);
      cnt = (r == 0) ? 31 : $urandom_range(31, 1);
      start_run(cnt, 1'b0, 0, 16'h0, eff, w0);
      stream(HOLD + 1, 14, 1'b0, 0);
      finish_check(eff, 1'b0, w0);
    end

    // Reset in the 2nd cycle of the word-3 window, then re-stream from word 0
    start_run(6, 1'b0, 0, 16'h0, eff, w0);
    cyc = 0;
    while (!(bus_if.io_en && bus_if.word_idx == 3) && cyc < 1000) begin
      bus_if.instFlag = ((cyc % 10) == 0);
      @(negedge clk);
      cyc++;
    end
    bus_if.instFlag = 1'b0;
    check("reach_word3", cyc < 1000, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    exp_q.delete();
    reset = 1'b0;
    start_run(6, 1'b0, 0, 16'h0, eff, w0);
    stream(HOLD + 1, 20, 1'b0, 0);
    finish_check(eff, 1'b0, w0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
